uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  UART transmitter: the transmit counterpart of the UART receiver, with matching
//  framing (8N1, optional parity) and baud timing from the 25 MHz pixel-domain clock.
//  Bytes written by the host/debug logic are held in a small FIFO, then serialised
//  on uart_tx_o, LSB first. Used for status/echo output back to the PC terminal.
// PARAMETERS
//  CLK_FREQ    25_000_000  input clock frequency in Hz
//  BAUD_RATE   115200      line rate; CLKS_PER_BAUD = CLK_FREQ/BAUD_RATE, truncated (=217)
//  PARITY_EN   0           0: no parity bit; 1: parity bit inserted after data
//  PARITY_ODD  0           only when PARITY_EN=1. 0: even parity; 1: odd parity
//  FIFO_DEPTH  4           number of byte entries, power of 2, >=2
// PORTS
//  clk_i      in   1  single clock, 25 MHz
//  rst_i      in   1  asynchronous, active-high reset
//  data_i     in   8  byte to transmit
//  wr_i       in   1  write strobe; data_i is captured on the edge where wr_i=1 and full_o=0
//  full_o     out  1  FIFO full; writes are dropped while high
//  busy_o     out  1  1 when the FIFO is non-empty or a frame is in progress
//  uart_tx_o  out  1  serial line, idle high, registered output
// BEHAVIOUR
//  Reset (async, rst_i=1): uart_tx_o=1, full_o=0, busy_o=0, FIFO empty, FSM=IDLE,
//   baud counter=0, bit counter=0. Asserting reset mid-frame aborts the frame and
//   drops the line high immediately. Queued bytes are discarded.
//  FSM states: IDLE, START, DATA, PARITY, STOP.
//   IDLE:   if FIFO non-empty, pop the head into an 8-bit shift register and go to START.
//   START:  uart_tx_o=0 for CLKS_PER_BAUD cycles, then go to DATA.
//   DATA:   uart_tx_o=shift[0] for CLKS_PER_BAUD cycles per bit; shift right 8 times.
//           After bit 7, go to PARITY if PARITY_EN=1, otherwise go to STOP.
//   PARITY: uart_tx_o = ^byte ^ PARITY_ODD for CLKS_PER_BAUD cycles, then go to STOP.
//   STOP:   uart_tx_o=1 for CLKS_PER_BAUD cycles. At the end, if the FIFO is non-empty,
//           pop and go directly to START (no idle gap); otherwise go to IDLE.
//  Baud counter: 16 bit, held at 0 in IDLE; wraps CLKS_PER_BAUD-1 -> 0. Bit ends on wrap.
//  Every bit is exactly CLKS_PER_BAUD cycles wide on uart_tx_o.
//  Frame length: (10 + PARITY_EN) * CLKS_PER_BAUD cycles.
//  Latency: write at edge N into an empty FIFO with FSM idle -> uart_tx_o falls at edge N+2.
//  FIFO: write when wr_i & !full_o; pop on FSM load.
//   Simultaneous push and pop: legal at any fill level below full; count unchanged.
//   Full with a same-cycle pop: the write is still dropped, because full_o gates the push.
//   Pointers wrap modulo FIFO_DEPTH.
//   full_o and count are registered; full_o asserts on the edge that stores the
//   FIFO_DEPTH-th entry.
//  busy_o = (state != IDLE) | !fifo_empty, combinational from registers.
//  All outputs are glitch-free: uart_tx_o is driven from a flop.
// STRUCTURE
//  uart_pkg:  state localparams (IDLE..STOP, 3 bit), BAUD_WIDTH=16, DATA_WIDTH=8,
//             CLKS_PER_BAUD computation. Shared with the receiver.
//  uart_tx_fifo: sub-module, synchronous FIFO parameterised by width and depth.
//             Ports: push, pop, din, dout, empty, full. Async active-high reset.
//  Top level: FSM, baud counter, 3-bit bit counter, shift register, output flop.
// TESTING
//  1 Reset: hold rst_i, toggle wr_i -> uart_tx_o=1, busy_o=0, full_o=0; nothing queued.
//  2 Write 0x55, PARITY_EN=0 -> line shows 0,1,0,1,0,1,0,1,0,1, each bit 217 cycles;
//    start bit falls 2 edges after the write; busy_o drops after the stop bit.
//  3 PARITY_EN=1, write 0xA5 -> parity bit 0 (even) / 1 (PARITY_ODD=1); frame is 11*217 cycles.
//  4 Burst of 6 writes 0x01..0x06 on consecutive cycles, FIFO_DEPTH=4 -> full_o rises;
//    the writes made while full_o=1 are dropped; only the accepted bytes are sent, in
//    order, with each stop bit followed directly by the next start bit.
//  5 Pulse rst_i in DATA bit 3 of a frame -> uart_tx_o=1 in the same cycle; FIFO empties;
//    a new write afterwards is sent correctly.
//  6 Loopback uart_tx_o -> UART receiver at the same BAUD_RATE; send all 256 byte values
//    -> the receiver data output matches every byte in order.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, datapath widths and baud divisor.
// Imported by both the transmitter and the receiver so framing stays consistent.
package uart_pkg;

  localparam int BAUD_WIDTH = 16;
  localparam int DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // Baud divisor, truncated; 25 MHz / 115200 gives 217.
  function automatic int clks_per_baud(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Host-side bundle of the UART transmitter: byte write port, status and serial line.
// The host drives through master; the transmitter sits behind slave.
interface uart_tx_if;

  logic [uart_pkg::DATA_WIDTH-1:0] data_i;
  logic                            wr_i;
  logic                            full_o;
  logic                            busy_o;
  logic                            uart_tx_o;

  modport master (output data_i, wr_i, input full_o, busy_o, uart_tx_o);
  modport slave  (input data_i, wr_i, output full_o, busy_o, uart_tx_o);

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with registered fill count and full flag; DEPTH must be a power of 2.
// Push is ignored while full and pop while empty, so callers may assert them blindly.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LAST_FREE = (AW + 1)'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      // A simultaneous push and pop leaves count and full untouched.
      case ({do_push, do_pop})
        2'b10: begin
          count <= count + (AW + 1)'(1);
          full  <= (count == LAST_FREE);
        end
        2'b01: begin
          count <= count - (AW + 1)'(1);
          full  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO feeding an 8N1 (optional parity) serialiser, LSB first.
// The line flop follows the frame state one cycle later, giving a glitch-free output.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 25_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  uart_tx_if.slave  bus
);

  localparam int                    CLKS_PER_BAUD = clks_per_baud(CLK_FREQ, BAUD_RATE);
  localparam logic [BAUD_WIDTH-1:0] BAUD_LAST     = BAUD_WIDTH'(CLKS_PER_BAUD - 1);

  uart_state_t           state;
  logic [BAUD_WIDTH-1:0] baud_cnt;
  logic [2:0]            bit_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic                  par_bit;
  logic                  tx_q;

  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  baud_end;
  logic                  load;

  assign baud_end = (baud_cnt == BAUD_LAST);
  // Pop from idle, or at the end of a stop bit so frames run back to back.
  assign load     = ~fifo_empty & ((state == IDLE) | ((state == STOP) & baud_end));

  uart_tx_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (bus.wr_i),
    .pop   (load),
    .din   (bus.data_i),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      if (state == IDLE || baud_end) baud_cnt <= '0;
      else                           baud_cnt <= baud_cnt + BAUD_WIDTH'(1);

      case (state)
        IDLE: begin
          tx_q <= 1'b1;
          if (load) begin
            shift   <= fifo_dout;
            par_bit <= (^fifo_dout) ^ (PARITY_ODD != 0);
            bit_cnt <= '0;
            state   <= START;
          end
        end
        START: begin
          tx_q <= 1'b0;
          if (baud_end) state <= DATA;
        end
        DATA: begin
          tx_q <= shift[0];
          if (baud_end) begin
            shift   <= shift >> 1;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          tx_q <= par_bit;
          if (baud_end) state <= STOP;
        end
        STOP: begin
          tx_q <= 1'b1;
          if (baud_end) begin
            if (load) begin
              shift   <= fifo_dout;
              par_bit <= (^fifo_dout) ^ (PARITY_ODD != 0);
              bit_cnt <= '0;
              state   <= START;
            end else begin
              state   <= IDLE;
            end
          end
        end
        default: begin
          tx_q  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.uart_tx_o = tx_q;
  assign bus.full_o    = fifo_full;
  assign bus.busy_o    = (state != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: reset, latency/bit timing, parity, FIFO overflow,
// mid-frame reset and a fast-baud loopback of all byte values.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int CPB      = 217;
  localparam int CPB_FAST = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #20 clk = ~clk;

  uart_tx_if if0 ();
  uart_tx_if if1 ();
  uart_tx_if if2 ();
  uart_tx_if if3 ();

  uart_tx dut0 (.clk_i(clk), .rst_i(rst), .bus(if0));
  uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) dut1 (.clk_i(clk), .rst_i(rst), .bus(if1));
  uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) dut2 (.clk_i(clk), .rst_i(rst), .bus(if2));
  uart_tx #(.BAUD_RATE(6_250_000)) dut3 (.clk_i(clk), .rst_i(rst), .bus(if3));

  logic [3:0] line_w;
  assign line_w = {if3.uart_tx_o, if2.uart_tx_o, if1.uart_tx_o, if0.uart_tx_o};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Waits for a start bit, then samples each bit at its centre on negative edges.
  task automatic rx_frame(input int idx, input int cpb, input bit par_en, input int timeout,
                          output logic [7:0] data, output logic par, output int gap);
    gap  = 0;
    data = '0;
    par  = 1'b0;
    do begin
      @(negedge clk);
      gap++;
    end while (line_w[idx] !== 1'b0 && gap < timeout);
    check("rx_start_seen", 32'(line_w[idx]), 32'd0);
    repeat (cpb / 2) @(negedge clk);
    check("rx_start_mid", 32'(line_w[idx]), 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (cpb) @(negedge clk);
      data[i] = line_w[idx];
    end
    if (par_en) begin
      repeat (cpb) @(negedge clk);
      par = line_w[idx];
    end
    repeat (cpb) @(negedge clk);
    check("rx_stop", 32'(line_w[idx]), 32'd1);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d, d2;
    logic       p, p2;
    int         gap, gap2, len, lows;
    logic       cur;
    logic [7:0] burst_exp [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    logic       full_exp  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    {if0.wr_i, if1.wr_i, if2.wr_i, if3.wr_i} = '0;
    if0.data_i = '0; if1.data_i = '0; if2.data_i = '0; if3.data_i = '0;

    // 1: writes while in reset are ignored
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if0.wr_i   = ~if0.wr_i;
      if0.data_i = 8'hAA;
    end
    @(negedge clk);
    if0.wr_i = 1'b0;
    check("rst_line", 32'(if0.uart_tx_o), 32'd1);
    check("rst_busy", 32'(if0.busy_o), 32'd0);
    check("rst_full", 32'(if0.full_o), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_busy", 32'(if0.busy_o), 32'd0);
    check("post_rst_line", 32'(if0.uart_tx_o), 32'd1);

    // 2: 0x55, latency and exact bit widths
    if0.data_i = 8'h55;
    if0.wr_i   = 1'b1;
    @(negedge clk);
    if0.wr_i = 1'b0;
    check("lat_n0", 32'(if0.uart_tx_o), 32'd1);
    check("busy_queued", 32'(if0.busy_o), 32'd1);
    @(negedge clk);
    check("lat_n1", 32'(if0.uart_tx_o), 32'd1);
    @(negedge clk);
    check("lat_n2", 32'(if0.uart_tx_o), 32'd0);
    cur = 1'b0;
    for (int k = 0; k < 9; k++) begin
      len = 1;
      forever begin
        @(negedge clk);
        if (if0.uart_tx_o !== cur || len > 1000) break;
        len++;
      end
      check($sformatf("run%0d_len", k), 32'(len), 32'(CPB));
      cur = ~cur;
    end
    check("stop_level", 32'(if0.uart_tx_o), 32'd1);
    repeat (CPB - 1) @(negedge clk);
    check("stop_end_line", 32'(if0.uart_tx_o), 32'd1);
    check("stop_end_busy", 32'(if0.busy_o), 32'd0);

    // 3: 0xA5 with even and odd parity, 11-bit frame length
    @(negedge clk);
    if1.data_i = 8'hA5; if1.wr_i = 1'b1;
    if2.data_i = 8'hA5; if2.wr_i = 1'b1;
    fork
      rx_frame(1, CPB, 1'b1, 50, d, p, gap);
      rx_frame(2, CPB, 1'b1, 50, d2, p2, gap2);
      begin
        @(negedge clk);
        if1.wr_i = 1'b0;
        if2.wr_i = 1'b0;
      end
    join
    check("par_even_data", 32'(d), 32'hA5);
    check("par_even_bit", 32'(p), 32'd0);
    check("par_odd_data", 32'(d2), 32'hA5);
    check("par_odd_bit", 32'(p2), 32'd1);
    repeat (CPB / 2 - 1) @(negedge clk);
    check("par_busy_before_end", 32'({if2.busy_o, if1.busy_o}), 32'h3);
    @(negedge clk);
    check("par_busy_at_end", 32'({if2.busy_o, if1.busy_o}), 32'h0);

    // 4: burst of six into a 4-deep FIFO; the sixth is dropped
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          check($sformatf("burst_full%0d", i), 32'(if0.full_o), 32'(full_exp[i]));
          if0.data_i = 8'(i + 1);
          if0.wr_i   = 1'b1;
          @(negedge clk);
        end
        if0.wr_i = 1'b0;
      end
      begin
        for (int f = 0; f < 5; f++) begin
          rx_frame(0, CPB, 1'b0, (f == 0) ? 50 : 3 * CPB, d, p, gap);
          check($sformatf("burst_data%0d", f), 32'(d), 32'(burst_exp[f]));
          if (f > 0) check($sformatf("burst_gap%0d", f), 32'(gap), 32'(CPB - CPB / 2));
        end
      end
    join
    repeat (CPB) @(negedge clk);
    check("burst_drained_busy", 32'(if0.busy_o), 32'd0);
    check("burst_drained_full", 32'(if0.full_o), 32'd0);

    // 5: reset during data bit 3, queued byte discarded
    if0.data_i = 8'h00; if0.wr_i = 1'b1;
    @(negedge clk);
    if0.data_i = 8'h7E;
    @(negedge clk);
    if0.wr_i = 1'b0;
    gap = 0;
    while (if0.uart_tx_o !== 1'b0 && gap < 50) begin
      @(negedge clk);
      gap++;
    end
    check("abort_start", 32'(if0.uart_tx_o), 32'd0);
    repeat (CPB / 2 + 4 * CPB) @(negedge clk);
    check("abort_bit3", 32'(if0.uart_tx_o), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("abort_line", 32'(if0.uart_tx_o), 32'd1);
    check("abort_busy", 32'(if0.busy_o), 32'd0);
    check("abort_full", 32'(if0.full_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (if0.uart_tx_o !== 1'b1 || if0.busy_o !== 1'b0) lows++;
    end
    check("abort_quiet", 32'(lows), 32'd0);
    if0.data_i = 8'h3C; if0.wr_i = 1'b1;
    fork
      rx_frame(0, CPB, 1'b0, 50, d, p, gap);
      begin
        @(negedge clk);
        if0.wr_i = 1'b0;
      end
    join
    check("after_abort_data", 32'(d), 32'h3C);

    // 6: all 256 values at 4 clocks per bit, checked in order
    fork
      begin
        int i = 0;
        int cyc = 0;
        while (i < 256 && cyc < 20000) begin
          if (if3.full_o === 1'b0) begin
            if3.data_i = 8'(i);
            if3.wr_i   = 1'b1;
            i++;
          end else begin
            if3.wr_i = 1'b0;
          end
          @(negedge clk);
          cyc++;
        end
        if3.wr_i = 1'b0;
      end
      begin
        for (int k = 0; k < 256; k++) begin
          rx_frame(3, CPB_FAST, 1'b0, 200, d, p, gap);
          check($sformatf("loop_%0d", k), 32'(d), 32'(k));
        end
      end
    join
    repeat (2 * CPB_FAST) @(negedge clk);
    check("loop_idle", 32'(if3.busy_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
